// File: rtl/tb_err_sched_pkg.sv
// -----------------------------------------------------------------------------
// tb_err_sched_pkg
// Shared definitions for the testbench error-report scheduler:
//   ID_W(n)  - index width needed to name one of n requesters (min 1 bit)
//   rpt_t    - report record {id, code} at the default 4-requester/8-bit shape
// -----------------------------------------------------------------------------
package tb_err_sched_pkg;

  function automatic int ID_W(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int RPT_ID_W   = 2;
  localparam int RPT_CODE_W = 8;

  typedef struct packed {
    logic [RPT_ID_W-1:0]   id;
    logic [RPT_CODE_W-1:0] code;
  } rpt_t;

endpackage

// File: rtl/tb_err_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_rr_arb
// Round-robin arbiter. Grants the first set request at or after the pointer,
// searching upward with wrap. The pointer moves past the winner only when the
// caller takes the grant (i_adv).
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   i_req           : request vector
//   i_adv           : grant is consumed this cycle, advance the pointer
//   o_gnt           : one-hot grant
//   o_gnt_idx       : index of the granted requester
//   o_any           : at least one request is set
// -----------------------------------------------------------------------------
module tb_rr_arb
  import tb_err_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [N-1:0]       i_req,
  input  logic               i_adv,
  output logic [N-1:0]       o_gnt,
  output logic [ID_W(N)-1:0] o_gnt_idx,
  output logic               o_any
);

  localparam int IW = ID_W(N);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_ptr_nxt;
  logic [IW:0]   w_sum;
  logic [N-1:0]  w_rot;
  logic          w_found;

  // Rotate requests so the pointer position sits at bit 0, then pick the lowest
  // set bit; the winner's absolute index is ptr + offset, folded back mod N.
  always_comb begin
    w_rot   = N'({i_req, i_req} >> r_ptr);
    w_found = 1'b0;
    w_sum   = {(IW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IW+1)'(k);
      end else begin
        w_found = w_found;
      end
    end
    if (w_sum >= (IW+1)'(N)) begin
      w_idx = IW'(w_sum - (IW+1)'(N));
    end else begin
      w_idx = w_sum[IW-1:0];
    end
    if (w_idx == IW'(N-1)) begin
      w_ptr_nxt = {IW{1'b0}};
    end else begin
      w_ptr_nxt = w_idx + IW'(1);
    end
    if (w_found) begin
      o_gnt = {{(N-1){1'b0}}, 1'b1} << w_idx;
    end else begin
      o_gnt = {N{1'b0}};
    end
  end

  // Pointer register: moves past the winner only when the grant is taken.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ptr <= {IW{1'b0}};
    end else if (i_adv && w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_gnt_idx = w_idx;
  assign o_any     = w_found;

endmodule

// File: rtl/tb_err_sched.sv
// -----------------------------------------------------------------------------
// tb_err_sched
// Serializes error events from N_REQ checkers onto one report channel.
// Each requester owns a one-deep slot; a round-robin arbiter picks which slot
// feeds the registered output stage. Accepted reports are counted (saturating)
// and a sticky halt stops further output loads once MAX_ERRS is reached.
//   clk, arst_n        : clock, asynchronous active-low reset
//   req_vld/req_code   : per-requester event, code slice i at [i*CODE_W +: CODE_W]
//   req_rdy            : slot i empty
//   rpt_vld/id/code    : report channel, consumed when rpt_vld & rpt_rdy
//   rpt_rdy            : consumer ready
//   clr                : synchronous clear of err_cnt and halt
//   err_cnt            : accepted reports, saturating
//   halt               : sticky budget-exhausted flag
// -----------------------------------------------------------------------------
module tb_err_sched
  import tb_err_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CODE_W   = 8,
  parameter int CNT_W    = 16,
  parameter int MAX_ERRS = 0
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*CODE_W-1:0] req_code,
  output logic [N_REQ-1:0]        req_rdy,
  output logic                    rpt_vld,
  output logic [ID_W(N_REQ)-1:0]  rpt_id,
  output logic [CODE_W-1:0]       rpt_code,
  input  logic                    rpt_rdy,
  input  logic                    clr,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    halt
);

  localparam int               IW      = ID_W(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_ERRS);
  localparam bit               HALT_EN = (MAX_ERRS != 0);

  if ((N_REQ < 2) || (N_REQ > 16)) begin : g_n_req_range
    $error("tb_err_sched: N_REQ must be within 2..16");
  end

  logic [N_REQ-1:0]  r_pend;
  logic [CODE_W-1:0] r_slot_code [N_REQ];
  logic              r_rpt_vld;
  logic [IW-1:0]     r_rpt_id;
  logic [CODE_W-1:0] r_rpt_code;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halt;

  logic [N_REQ-1:0]  w_gnt;
  logic [IW-1:0]     w_gnt_idx;
  logic              w_any;
  logic              w_acc;
  logic              w_load;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_halt_nxt;

  tb_rr_arb #(
    .N (N_REQ)
  ) u_arb (
    .i_clk     (clk),
    .i_arst_n  (arst_n),
    .i_req     (r_pend),
    .i_adv     (w_load),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Next counter / halt values. Load is also gated by the halt being raised
  // this very cycle, so the accept that exhausts the budget is the last one.
  always_comb begin
    w_acc = r_rpt_vld & rpt_rdy;
    if (clr) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_acc && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
    if (clr) begin
      w_halt_nxt = 1'b0;
    end else begin
      w_halt_nxt = r_halt | (HALT_EN && (w_cnt_nxt >= MAX_C));
    end
    w_load = (~r_rpt_vld | rpt_rdy) & w_any & ~r_halt & ~w_halt_nxt;
  end

  // Slots: capture when empty, release when the output stage takes the grant.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pend <= {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
        r_slot_code[i] <= {CODE_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_vld[i] && !r_pend[i]) begin
          r_pend[i]      <= 1'b1;
          r_slot_code[i] <= req_code[i*CODE_W +: CODE_W];
        end else if (w_load && w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage: payload only changes on a load, so it is stable under stall.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rpt_vld  <= 1'b0;
      r_rpt_id   <= {IW{1'b0}};
      r_rpt_code <= {CODE_W{1'b0}};
    end else if (w_load) begin
      r_rpt_vld  <= 1'b1;
      r_rpt_id   <= w_gnt_idx;
      r_rpt_code <= r_slot_code[w_gnt_idx];
    end else if (rpt_rdy) begin
      r_rpt_vld  <= 1'b0;
    end
  end

  // Error counter and sticky halt.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_halt <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_halt <= w_halt_nxt;
    end
  end

  assign req_rdy  = ~r_pend;
  assign rpt_vld  = r_rpt_vld;
  assign rpt_id   = r_rpt_id;
  assign rpt_code = r_rpt_code;
  assign err_cnt  = r_cnt;
  assign halt     = r_halt;

endmodule
